// File: rtl/calc_pkg.sv
// calc_pkg: opcode constants, sequencer states and program entry type shared by the
// sequencer and the calculator datapath.
package calc_pkg;
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_CLR = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_MOD = 4'b0110;
  localparam logic [3:0] OP_RST = 4'b1111;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_FIN} state_t;
  typedef struct packed {
    logic [15:0] opnd;
    logic [3:0]  op;
  } entry_t;
endpackage

// File: rtl/calc_op_sequencer_if.sv
// calc_op_sequencer_if: program load, calculator drive and result return ports of the sequencer.
interface calc_op_sequencer_if #(parameter int DEPTH = 16);
  logic                     ld_valid;
  logic                     ld_ready;
  logic [15:0]              ld_opnd;
  logic [3:0]               ld_op;
  logic                     start;
  logic [15:0]              in1;
  logic [3:0]               op;
  logic [31:0]              out_in;
  logic [1:0]               err_in;
  logic                     res_valid;
  logic                     res_ready;
  logic [31:0]              res_data;
  logic [1:0]               res_err;
  logic [$clog2(DEPTH)-1:0] res_idx;
  logic                     busy;
  logic                     done;
  logic                     fault;
  modport master (
    input  ld_valid, ld_opnd, ld_op, start, out_in, err_in, res_ready,
    output ld_ready, in1, op, res_valid, res_data, res_err, res_idx, busy, done, fault
  );
  modport slave (
    output ld_valid, ld_opnd, ld_op, start, out_in, err_in, res_ready,
    input  ld_ready, in1, op, res_valid, res_data, res_err, res_idx, busy, done, fault
  );
endinterface

// File: rtl/calc_prog_mem.sv
// calc_prog_mem: program store, one synchronous write port and one asynchronous read port.
module calc_prog_mem
  import calc_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);
  entry_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: loads an (operand, opcode) program and steps it through the calculator,
// returning one captured result per entry. Define HALT_ON_ERR_EN to stop on the first erroring result.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2
) (
  input logic                 clk,
  input logic                 rst,
  calc_op_sequencer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(SETTLE + 1);
  localparam logic [WW-1:0] W_LAST = WW'(SETTLE - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
`ifdef HALT_ON_ERR_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif
  state_t state, next;
  logic [AW:0] count;
  logic [AW-1:0] ptr;
  logic [WW-1:0] wcnt;
  logic [15:0] in1_q;
  logic [1:0] err_q;
  logic [31:0] res_data;
  logic [1:0] res_err;
  logic [AW-1:0] res_idx;
  logic we, go, cap, hs, last;
  entry_t rd;
  calc_prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(count[AW-1:0]),
    .wdata({bus.ld_opnd, bus.ld_op}),
    .raddr(ptr),
    .rdata(rd)
  );
  assign we   = bus.ld_valid && bus.ld_ready;
  assign go   = state == S_IDLE && bus.start && count != '0;
  assign cap  = state == S_WAIT && wcnt == W_LAST;
  assign hs   = state == S_CAPTURE && bus.res_ready;
  assign last = ({1'b0, ptr} == count - 1'b1) || (HALT && res_err != 2'b00);
  assign bus.res_data = res_data;
  assign bus.res_err  = res_err;
  assign bus.res_idx  = res_idx;
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : next;
  always_comb begin
    next          = state;
    bus.ld_ready  = !rst && state == S_IDLE && count < FULL;
    bus.op        = state == S_ISSUE ? rd.op : OP_NOP;
    bus.in1       = state == S_ISSUE ? rd.opnd : in1_q;
    bus.res_valid = state == S_CAPTURE;
    bus.busy      = state != S_IDLE;
    bus.done      = state == S_FIN;
    case (state)
      S_IDLE:    next = go ? S_ISSUE : S_IDLE;
      S_ISSUE:   next = S_WAIT;
      S_WAIT:    next = cap ? S_CAPTURE : S_WAIT;
      S_CAPTURE: next = !bus.res_ready ? S_CAPTURE : last ? S_FIN : S_ISSUE;
      default:   next = S_IDLE;
    endcase
  end
  // ERR is only valid while the op is live, so it is held from ISSUE until capture
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      ptr      <= '0;
      wcnt     <= '0;
      in1_q    <= '0;
      err_q    <= '0;
      res_data <= '0;
      res_err  <= '0;
      res_idx  <= '0;
    end else begin
      if (we) count <= count + 1'b1;
      if (go) ptr <= '0;
      if (hs && !last) ptr <= ptr + 1'b1;
      if (state == S_ISSUE) begin
        in1_q <= rd.opnd;
        err_q <= bus.err_in;
      end
      wcnt <= state == S_WAIT ? wcnt + 1'b1 : '0;
      if (cap) begin
        res_data <= bus.out_in;
        res_err  <= err_q;
        res_idx  <= ptr;
      end
    end
  end
`ifdef HALT_ON_ERR_EN
  logic fault;
  always_ff @(posedge clk)
    if (rst || go) fault <= 1'b0;
    else if (cap && err_q != 2'b00) fault <= 1'b1;
  assign bus.fault = fault;
`else
  assign bus.fault = 1'b0;
`endif
endmodule
